// File: rtl/noc_input_demux.sv
`default_nettype none
// ============================================================================
// Module   : noc_input_demux
// Purpose  : Router input port - flit FIFO, XY route on head flit, packet
//            steering to one of five outputs (N/S/E/W/L).
// Revision : 1.0 - initial release
// ============================================================================
module noc_input_demux #(
    parameter int DEPTH = 4,
    parameter int MY_X  = 0,
    parameter int MY_Y  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [1:0] in_type,
    output logic [4:0] out_valid,
    input  logic [4:0] out_ready,
    output logic [7:0] out_data,
    output logic [1:0] out_type,
    output logic [2:0] route_sel,
    output logic       err
);

    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = (c_ptr_w)'(1);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [1:0]         c_my_x    = 2'(MY_X);
    localparam logic [1:0]         c_my_y    = 2'(MY_Y);

    localparam logic [2:0] c_route_n    = 3'b000;
    localparam logic [2:0] c_route_s    = 3'b001;
    localparam logic [2:0] c_route_e    = 3'b010;
    localparam logic [2:0] c_route_w    = 3'b011;
    localparam logic [2:0] c_route_l    = 3'b100;
    localparam logic [2:0] c_route_none = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    logic [9:0]         r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    state_t             r_state;
    logic [2:0]         r_route_sel;
    logic               r_err;

    logic       w_empty;
    logic       w_full;
    logic       w_push;
    logic       w_pop;
    logic       w_xfer;
    logic       w_stray;
    logic [7:0] w_head_data;
    logic [1:0] w_head_type;
    logic [1:0] w_dest_x;
    logic [1:0] w_dest_y;
    logic [2:0] w_route;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_depth);
    assign in_ready = rst_n & ~w_full;
    assign w_push   = in_valid & in_ready;

    assign {w_head_type, w_head_data} = r_mem[r_rd_ptr];
    assign w_dest_x = w_head_data[3:2];
    assign w_dest_y = w_head_data[1:0];

    // Type bit 0 marks a packet start (head/single), bit 1 a packet end (tail/single).
    assign w_stray = (r_state == ST_IDLE) & ~w_empty & ~w_head_type[0];
    assign w_xfer  = |(out_valid & out_ready);
    assign w_pop   = w_xfer | w_stray;

    always_comb begin
        w_route = c_route_l;
        if (w_dest_x > c_my_x) begin
            w_route = c_route_e;
        end else if (w_dest_x < c_my_x) begin
            w_route = c_route_w;
        end else if (w_dest_y > c_my_y) begin
            w_route = c_route_n;
        end else if (w_dest_y < c_my_y) begin
            w_route = c_route_s;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_type, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_route_sel <= c_route_none;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        if (w_head_type[0]) begin
                            r_route_sel <= w_route;
                            r_state     <= ST_LOCKED;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_xfer && w_head_type[1]) begin
                        r_route_sel <= c_route_none;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_route_sel <= c_route_none;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_port
        assign out_valid[i] = (r_state == ST_LOCKED) & ~w_empty & (r_route_sel == 3'(i));
    end

    // Empty FIFO presents zeros so reset values are visible without clearing storage.
    assign out_data  = w_empty ? 8'h00 : w_head_data;
    assign out_type  = w_empty ? 2'b00 : w_head_type;
    assign route_sel = r_route_sel;
    assign err       = r_err;

endmodule
`default_nettype wire
